// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci stream checker.
package fib_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int CNT_W     = 16;
    localparam int SEED_A    = 1;
    localparam int SEED_B    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        FAIL  = 2'd3
    } fib_state_e;

endpackage

// File: rtl/fibonacci_checker_if.sv
// Beat stream carrying one pair of consecutive Fibonacci terms per transfer.
interface fibonacci_checker_if #(
    parameter int WIDTH = fib_pkg::DEF_WIDTH
) ();

    // A beat transfers on a rising clk edge where in_valid and in_ready are both 1;
    // the producer holds in_a/in_b stable while in_valid is high and unaccepted.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    modport master (output in_valid, output in_a, output in_b, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, output in_ready);

endinterface

// File: rtl/fib_pair_next.sv
// Next reference pair of the stream: (a, b) -> (a+b, a+2b), modulo 2^WIDTH.
module fib_pair_next #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] next_a_o,
    output logic [WIDTH-1:0] next_b_o
);

    assign next_a_o = a_i + b_i;
    assign next_b_o = next_a_o + b_i;

endmodule

// File: rtl/fibonacci_checker.sv
// Checks a beat stream against the Fibonacci sequence over one run of N_BEATS beats.
// Define FIB_CHECK_RESYNC_EN to resync on a mismatch instead of stopping in FAIL.
module fibonacci_checker
    import fib_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_BEATS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    fibonacci_checker_if.slave   bus,
    output logic [CNT_W-1:0]     beat_cnt,
    output logic                 err,
    output logic [CNT_W-1:0]     err_idx,
    output logic                 done,
    output logic                 pass,
    output fib_state_e           state
);

    localparam logic [WIDTH-1:0] SEED_A_W = WIDTH'(SEED_A);
    localparam logic [WIDTH-1:0] SEED_B_W = WIDTH'(SEED_B);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS);

    fib_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] ref_a_q, ref_a_d;
    logic [WIDTH-1:0] ref_b_q, ref_b_d;

    logic [WIDTH-1:0] nxt_a, nxt_b, exp_a, exp_b;
    logic [CNT_W-1:0] cnt_inc;
    logic             hs, mismatch;

    fib_pair_next #(.WIDTH(WIDTH)) u_pair_next (
        .a_i      (ref_a_q),
        .b_i      (ref_b_q),
        .next_a_o (nxt_a),
        .next_b_o (nxt_b)
    );

    // start has priority, so a beat offered alongside it is never taken.
    assign bus.in_ready = ((state_q == ARMED) || (state_q == RUN)) && !start;

    assign hs       = bus.in_valid && bus.in_ready;
    assign exp_a    = (state_q == ARMED) ? SEED_A_W : nxt_a;
    assign exp_b    = (state_q == ARMED) ? SEED_B_W : nxt_b;
    assign mismatch = (bus.in_a != exp_a) || (bus.in_b != exp_b);
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        done_d  = done_q;
        ref_a_d = ref_a_q;
        ref_b_d = ref_b_q;
        if (start) begin
            state_d = ARMED;
            cnt_d   = '0;
            idx_d   = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
            ref_a_d = SEED_A_W;
            ref_b_d = SEED_B_W;
        end else if (hs) begin
            // On a match the observed pair equals the expected one; on resync it becomes the new reference.
            cnt_d   = cnt_inc;
            ref_a_d = bus.in_a;
            ref_b_d = bus.in_b;
            state_d = RUN;
            if (mismatch) begin
                err_d = 1'b1;
                if (!err_q) idx_d = cnt_q;
`ifdef FIB_CHECK_RESYNC_EN
                state_d = RUN;
`else
                state_d = FAIL;
                done_d  = 1'b1;
`endif
            end
            if ((cnt_inc == LAST_CNT) && (state_d != FAIL)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ref_a_q <= SEED_A_W;
            ref_b_q <= SEED_B_W;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ref_a_q <= ref_a_d;
            ref_b_q <= ref_b_d;
        end
    end

    assign beat_cnt = cnt_q;
    assign err      = err_q;
    assign err_idx  = idx_q;
    assign done     = done_q;
    assign pass     = done_q && !err_q;
    assign state    = state_q;

endmodule

// File: doc/fibonacci_checker.md
FIBONACCI_CHECKER -- requirements
Module: fibonacci_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the term width.
REQ-002 The block SHALL have parameter N_BEATS, default 8, the number of beats in one checked run.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, a pulse that arms a new run.
REQ-006 The block SHALL have port in_valid, input, 1 bit, the producer's beat-valid signal.
REQ-007 The block SHALL have port in_ready, output, 1 bit, the checker's beat-accept signal.
REQ-008 The block SHALL have port in_a, input, WIDTH bits, the first term of the beat.
REQ-009 The block SHALL have port in_b, input, WIDTH bits, the second term of the beat.
REQ-010 The block SHALL have port beat_cnt, output, 16 bits, the number of beats accepted in this run.
REQ-011 The block SHALL have port err, output, 1 bit, a sticky mismatch flag.
REQ-012 The block SHALL have port err_idx, output, 16 bits, the beat index of the first mismatch.
REQ-013 The block SHALL have port done, output, 1 bit, asserted when the run is complete.
REQ-014 The block SHALL have port pass, output, 1 bit, asserted when done=1 and err=0.

Function
REQ-015 A handshake SHALL occur when in_valid and in_ready are both 1 on a rising clk edge.
REQ-016 Beat k SHALL carry two consecutive terms: in_a=F(2k+1), in_b=F(2k+2), with F(1)=F(2)=1.
REQ-017 All arithmetic SHALL be modulo 2^WIDTH; wrap-around is legal and is not an error.
REQ-018 The state machine SHALL have four states: IDLE, ARMED, RUN, FAIL.
REQ-019 IDLE SHALL go to ARMED on start.
REQ-020 ARMED SHALL expect the seed beat (1,1); on handshake it SHALL go to RUN.
REQ-021 RUN SHALL expect exp_a=a+b and exp_b=a+2b, where (a,b) is the previous reference pair.
REQ-022 When beat_cnt reaches N_BEATS, the block SHALL set done=1 and return to IDLE.
REQ-023 in_ready SHALL be 1 only in ARMED or RUN and only while start=0.
REQ-024 A beat offered in the same cycle as start SHALL NOT be accepted, checked or counted.
REQ-025 start in any state SHALL clear beat_cnt, err, err_idx, done and pass, and go to ARMED.
REQ-026 err, err_idx, beat_cnt and done SHALL be registered and update one cycle after the handshake that causes the change.
REQ-027 err_idx SHALL capture only the first mismatch of a run; later mismatches SHALL NOT overwrite it.
REQ-028 in_valid in IDLE or FAIL SHALL be ignored, and in_ready SHALL remain 0.
REQ-029 A mismatching beat SHALL still be counted in beat_cnt.

Reset
REQ-030 Asserting rst low SHALL asynchronously force state=IDLE and beat_cnt=0.
REQ-031 Asserting rst low SHALL asynchronously force err=0, err_idx=0, done=0, pass=0 and in_ready=0.
REQ-032 The reference pair SHALL reset to (1,1).
REQ-033 Reset mid-run SHALL discard the run; no output SHALL retain a pre-reset value.
REQ-034 Deassertion of rst SHALL take effect at the next clk edge.

Configuration
REQ-035 Macro FIB_CHECK_RESYNC_EN SHALL select mismatch handling.
REQ-036 With FIB_CHECK_RESYNC_EN defined, a mismatch SHALL set err, stay in RUN, and load the observed (in_a,in_b) as the new reference pair.
REQ-037 Without FIB_CHECK_RESYNC_EN, a mismatch SHALL set err and go to FAIL; FAIL SHALL be left only by start or rst.
REQ-038 In FAIL, done SHALL be 1 and pass SHALL be 0.

Structure
REQ-039 Package fib_pkg SHALL hold the state enum, the default WIDTH and the seed constants.
REQ-040 Sub-module fib_pair_next SHALL compute the next expected pair (a+b, a+2b) combinationally from (a,b).

Verification
REQ-041 N_BEATS=4: start, then beats (1,1),(2,3),(5,8),(13,21) -> done=1, pass=1, beat_cnt=4, err=0.
REQ-042 Start, then (1,1),(2,4) -> err=1 one cycle after beat 1, err_idx=1; without the macro, state=FAIL and in_ready=0.
REQ-043 N_BEATS=14, correct stream with beat 12 = (9489,55857) and beat 13 = (65346,55667) -> no err (wrap-around check).
REQ-044 start asserted with in_valid=1 in RUN -> that beat is not counted, beat_cnt=0, state=ARMED.
REQ-045 rst low after 2 beats -> all outputs 0 immediately, without waiting for a clk edge.
REQ-046 With the macro: (1,1),(2,4),(6,10) -> err_idx=1, no second error, done=1 with pass=0 at N_BEATS.
